// File: rtl/mc_sequencer_if.sv
// Shared instruction/data memory port: the sequencer is the master, memory answers with mem_ready.
interface mc_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter and memory-timeout trap.
module mc_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  dec_memtoreg,
    input  logic                  dec_memwrite,
    input  logic                  dec_pcsrc,
    input  logic                  dec_regdst,
    input  logic                  dec_regwrite,
    input  logic                  dec_branch,
    mc_sequencer_if.master        mem,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_branch_write,
    output logic                  ab_load,
    output logic                  alu_out_load,
    output logic                  mdr_load,
    output logic                  reg_write,
    output logic                  wb_sel_mem,
    output logic                  wb_dst_rd,
    output logic [2:0]            state,
    output logic [15:0]           instr_retired,
    output logic                  mem_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic             req_pending_q, req_pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      instr_retired_q, instr_retired_d;
    logic             mem_err_q, mem_err_d;
    logic             retire;
    logic             mem_req_c, mem_we_c, iord_c;

    always_comb begin
        state_d         = state_q;
        req_pending_d   = req_pending_q;
        mem_err_d       = mem_err_q;
        retire          = 1'b0;
        mem_req_c       = 1'b0;
        mem_we_c        = 1'b0;
        iord_c          = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        pc_branch_write = 1'b0;
        ab_load         = 1'b0;
        alu_out_load    = 1'b0;
        mdr_load        = 1'b0;
        reg_write       = 1'b0;
        wb_sel_mem      = 1'b0;
        wb_dst_rd       = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Once a fetch is issued it is held even if run drops.
                if (req_pending_q || run) begin
                    mem_req_c = 1'b1;
                    if (mem.mem_ready) begin
                        ir_write      = 1'b1;
                        pc_write      = 1'b1;
                        req_pending_d = 1'b0;
                        state_d       = S_DECODE;
                    end else begin
                        req_pending_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                ab_load = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_out_load = 1'b1;
                if (dec_branch) begin
                    pc_branch_write = dec_pcsrc;
                    retire          = 1'b1;
                    state_d         = S_FETCH;
                end else if (dec_memtoreg || dec_memwrite) begin
                    state_d = S_MEM;
                end else if (dec_regwrite) begin
                    state_d = S_WB;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                mem_we_c  = dec_memwrite;
                if (mem.mem_ready) begin
                    if (dec_memwrite) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_load = 1'b1;
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                wb_sel_mem = dec_memtoreg;
                wb_dst_rd  = dec_regdst;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                // Unreachable encodings are treated as a fault, like a timeout.
                state_d   = S_ERR;
                mem_err_d = 1'b1;
            end
        endcase

        // The counter is zero whenever no request is outstanding, so each new request starts from 0.
        cnt_d = '0;
        if (mem_req_c && !mem.mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == TIMEOUT) begin
                state_d   = S_ERR;
                mem_err_d = 1'b1;
            end
        end

        instr_retired_d = instr_retired_q + 16'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_FETCH;
            req_pending_q   <= 1'b0;
            cnt_q           <= '0;
            instr_retired_q <= 16'd0;
            mem_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_pending_q   <= req_pending_d;
            cnt_q           <= cnt_d;
            instr_retired_q <= instr_retired_d;
            mem_err_q       <= mem_err_d;
        end
    end

    assign mem.mem_req    = mem_req_c;
    assign mem.mem_we     = mem_we_c;
    assign mem.iord       = iord_c;
    assign state          = state_q;
    assign instr_retired  = instr_retired_q;
    assign mem_err        = mem_err_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench: each instruction is expanded into its expected per-cycle outputs and compared every cycle.
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        dec_memtoreg, dec_memwrite, dec_pcsrc, dec_regdst, dec_regwrite, dec_branch;
    logic        ir_write, pc_write, pc_branch_write, ab_load, alu_out_load, mdr_load;
    logic        reg_write, wb_sel_mem, wb_dst_rd, mem_err;
    logic [2:0]  state;
    logic [15:0] instr_retired;

    mc_sequencer_if mem_bus();

    mc_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .dec_memtoreg(dec_memtoreg), .dec_memwrite(dec_memwrite), .dec_pcsrc(dec_pcsrc),
        .dec_regdst(dec_regdst), .dec_regwrite(dec_regwrite), .dec_branch(dec_branch),
        .mem(mem_bus),
        .ir_write(ir_write), .pc_write(pc_write), .pc_branch_write(pc_branch_write),
        .ab_load(ab_load), .alu_out_load(alu_out_load), .mdr_load(mdr_load),
        .reg_write(reg_write), .wb_sel_mem(wb_sel_mem), .wb_dst_rd(wb_dst_rd),
        .state(state), .instr_retired(instr_retired), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        mem_req, mem_we, iord, ir_write, pc_write, pc_branch_write;
        logic        ab_load, alu_out_load, mdr_load, reg_write, wb_sel_mem, wb_dst_rd, mem_err;
        logic [15:0] retired;
    } obs_t;

    obs_t        act, exp_obs;
    logic        exp_valid = 1'b0;
    string       exp_tag = "";
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_cnt = 16'd0;
    logic        model_err = 1'b0;
    int          n;

    assign act = {state, mem_bus.mem_req, mem_bus.mem_we, mem_bus.iord, ir_write, pc_write,
                  pc_branch_write, ab_load, alu_out_load, mdr_load, reg_write, wb_sel_mem,
                  wb_dst_rd, mem_err, instr_retired};

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act !== exp_obs) begin
                errors++;
                $display("FAIL cycle %s: got st=%0d req=%b we=%b iord=%b irw=%b pcw=%b pcb=%b ab=%b alu=%b mdr=%b rw=%b wbm=%b rd=%b err=%b ret=%h ; required st=%0d req=%b we=%b iord=%b irw=%b pcw=%b pcb=%b ab=%b alu=%b mdr=%b rw=%b wbm=%b rd=%b err=%b ret=%h",
                         exp_tag,
                         act.st, act.mem_req, act.mem_we, act.iord, act.ir_write, act.pc_write,
                         act.pc_branch_write, act.ab_load, act.alu_out_load, act.mdr_load,
                         act.reg_write, act.wb_sel_mem, act.wb_dst_rd, act.mem_err, act.retired,
                         exp_obs.st, exp_obs.mem_req, exp_obs.mem_we, exp_obs.iord, exp_obs.ir_write,
                         exp_obs.pc_write, exp_obs.pc_branch_write, exp_obs.ab_load,
                         exp_obs.alu_out_load, exp_obs.mdr_load, exp_obs.reg_write,
                         exp_obs.wb_sel_mem, exp_obs.wb_dst_rd, exp_obs.mem_err, exp_obs.retired);
            end else begin
                $display("cycle %s ok: st=%0d ret=%h", exp_tag, act.st, act.retired);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end else begin
            $display("check %s ok: %h", name, got);
        end
    endtask

    function automatic obs_t idle_obs();
        obs_t o;
        o         = '0;
        o.retired = model_cnt;
        o.mem_err = model_err;
        return o;
    endfunction

    // One clock cycle: apply inputs just after the edge and publish what the outputs must be.
    task automatic step(input string tag, input obs_t e, input logic rdy, input logic run_v,
                        input logic [5:0] dec);
        @(posedge clk);
        #1;
        mem_bus.mem_ready = rdy;
        run               = run_v;
        {dec_memtoreg, dec_memwrite, dec_pcsrc, dec_regdst, dec_regwrite, dec_branch} = dec;
        exp_obs   = e;
        exp_tag   = tag;
        exp_valid = 1'b1;
    endtask

    // Expands one instruction into its cycle sequence from the phase rules.
    // fw/mw = wait cycles before mem_ready for the fetch and data access.
    task automatic do_instr(input string tag, input logic mtr, input logic mwr, input logic pcs,
                            input logic rdst, input logic rwr, input logic br,
                            input int fw, input int mw, input logic drop_run, output int ncyc);
        obs_t       e;
        logic [5:0] dec;
        logic       is_mem;
        dec    = {mtr, mwr, pcs, rdst, rwr, br};
        is_mem = mtr | mwr;
        ncyc   = 0;
        for (int i = 0; i <= fw; i++) begin
            e          = idle_obs();
            e.mem_req  = 1'b1;
            e.ir_write = (i == fw);
            e.pc_write = (i == fw);
            step({tag, "/F"}, e, i == fw, !(drop_run && i > 0), dec);
            ncyc++;
        end
        e = idle_obs(); e.st = 3'd1; e.ab_load = 1'b1;
        step({tag, "/D"}, e, 1'b0, 1'b0, dec); ncyc++;
        e = idle_obs(); e.st = 3'd2; e.alu_out_load = 1'b1; e.pc_branch_write = br & pcs;
        step({tag, "/X"}, e, 1'b0, 1'b0, dec); ncyc++;
        if (br || (!is_mem && !rwr)) begin
            model_cnt = model_cnt + 16'd1;
            return;
        end
        if (is_mem) begin
            for (int j = 0; j <= mw; j++) begin
                e = idle_obs(); e.st = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1;
                e.mem_we   = mwr;
                e.mdr_load = (j == mw) && !mwr;
                step({tag, "/M"}, e, j == mw, 1'b0, dec); ncyc++;
            end
            if (mwr) begin
                model_cnt = model_cnt + 16'd1;
                return;
            end
        end
        e = idle_obs(); e.st = 3'd4; e.reg_write = 1'b1; e.wb_sel_mem = mtr; e.wb_dst_rd = rdst;
        step({tag, "/W"}, e, 1'b0, 1'b0, dec); ncyc++;
        model_cnt = model_cnt + 16'd1;
    endtask

    task automatic idle(input string tag);
        step(tag, idle_obs(), 1'b0, 1'b0, 6'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        exp_valid         = 1'b0;
        run               = 1'b0;
        mem_bus.mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state",   32'(state), 32'd0);
        chk("rst_retired", 32'(instr_retired), 32'd0);
        chk("rst_err",     32'(mem_err), 32'd0);
        chk("rst_memreq",  32'(mem_bus.mem_req), 32'd0);
        model_cnt = 16'd0;
        model_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; mem_bus.mem_ready = 1'b0;
        {dec_memtoreg, dec_memwrite, dec_pcsrc, dec_regdst, dec_regwrite, dec_branch} = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_state", 32'(state), 32'd0);
        chk("reset_hold_req",   32'(mem_bus.mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idle("idle0");
        // add: zero-wait ALU op
        do_instr("add", 0, 0, 0, 1, 1, 0, 0, 0, 1'b0, n);
        chk("lat_add", 32'(n), 32'd4);
        idle("idle1");
        @(negedge clk); chk("ret_after_add", 32'(instr_retired), 32'd1);
        // lw with two wait cycles on both accesses
        do_instr("lw", 1, 0, 0, 0, 1, 0, 2, 2, 1'b0, n);
        chk("lat_lw", 32'(n), 32'd9);
        idle("idle2");
        do_instr("beq_t", 0, 0, 1, 0, 0, 1, 0, 0, 1'b0, n);
        chk("lat_beq", 32'(n), 32'd3);
        do_instr("beq_nt", 0, 0, 0, 0, 0, 1, 0, 0, 1'b0, n);
        // sw with run dropped after the first fetch cycle
        do_instr("sw", 0, 1, 0, 0, 0, 0, 2, 0, 1'b1, n);
        chk("lat_sw", 32'(n), 32'd6);
        do_instr("nop", 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, n);
        chk("lat_nop", 32'(n), 32'd3);
        idle("idle3");
        @(negedge clk); chk("ret_after_six", 32'(instr_retired), 32'd6);

        // fetch that never completes: 15 wait cycles then the trap
        for (int i = 0; i < 15; i++) begin
            obs_t e;
            e = idle_obs(); e.mem_req = 1'b1;
            step("tmo/F", e, 1'b0, 1'b1, 6'd0);
        end
        model_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            obs_t e;
            e = idle_obs(); e.st = 3'd6;
            step("err", e, 1'b1, 1'b1, 6'd0);
        end
        @(negedge clk);
        chk("err_state", 32'(state), 32'd6);
        chk("err_flag",  32'(mem_err), 32'd1);

        do_reset();
        idle("idle4");

        // preload the counter near its wrap point, then retire two nops
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        force dut.instr_retired_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.instr_retired_q;
        model_cnt = 16'hFFFE;
        idle("idle5");
        do_instr("nopA", 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, n);
        idle("idle6");
        @(negedge clk); chk("ret_ffff", 32'(instr_retired), 32'h0000FFFF);
        do_instr("nopB", 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, n);
        idle("idle7");
        @(negedge clk); chk("ret_wrap", 32'(instr_retired), 32'd0);
        do_instr("add2", 0, 0, 0, 1, 1, 0, 1, 0, 1'b0, n);
        idle("idle8");

        // lw stalled in MEM, then reset arrives mid-access
        begin
            obs_t e;
            e = idle_obs(); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
            step("lwr/F", e, 1'b1, 1'b1, 6'b100010);
            e = idle_obs(); e.st = 3'd1; e.ab_load = 1'b1;
            step("lwr/D", e, 1'b0, 1'b0, 6'b100010);
            e = idle_obs(); e.st = 3'd2; e.alu_out_load = 1'b1;
            step("lwr/X", e, 1'b0, 1'b0, 6'b100010);
            e = idle_obs(); e.st = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1;
            step("lwr/M", e, 1'b0, 1'b0, 6'b100010);
            step("lwr/M", e, 1'b0, 1'b0, 6'b100010);
        end
        do_reset();
        idle("idle9");
        do_instr("add3", 0, 0, 0, 0, 1, 0, 0, 0, 1'b0, n);
        idle("idle10");
        @(negedge clk); chk("ret_after_rst", 32'(instr_retired), 32'd1);

        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
